// File: rtl/sobel_window_gen.sv
// sobel_window_gen: builds a registered 3x3 pixel window from a raster-order
// pixel stream using two line buffers, for the downstream Sobel filter stage.
// Latency: 1 cycle from the accepting edge to window_valid/window_x/window_y.
// No backpressure: every pixel_valid cycle is accepted; gaps of any length are legal.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   pixel_input  incoming pixel, accepted when pixel_valid=1
//   pixel_valid  pixel qualifier
//   sof          start-of-frame, qualified by pixel_valid; forces coordinate (0,0)
//   pixel_window 3x3 window [row][col]; row 0 = y-2, col 0 = x-2
//   window_valid one-cycle strobe, window complete
//   window_x/_y  window centre coordinate (x-1, y-1)
//   frame_done   one-cycle strobe after the last pixel of a frame
//   sof_err      sticky: sof arrived while the counters were not at (0,0)
module sobel_window_gen #(
  parameter  int IMG_WIDTH  = 10,
  parameter  int IMG_HEIGHT = 10,
  parameter  int PIX_W      = 8,
  localparam int XW         = $clog2(IMG_WIDTH),
  localparam int YW         = $clog2(IMG_HEIGHT)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PIX_W-1:0]            pixel_input,
  input  logic                        pixel_valid,
  input  logic                        sof,
  output logic [2:0][2:0][PIX_W-1:0]  pixel_window,
  output logic                        window_valid,
  output logic [XW-1:0]               window_x,
  output logic [YW-1:0]               window_y,
  output logic                        frame_done,
  output logic                        sof_err
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  logic [PIX_W-1:0] lb1 [IMG_WIDTH];  // row y-1
  logic [PIX_W-1:0] lb2 [IMG_WIDTH];  // row y-2

  logic [XW-1:0]              x_q, x_d, eff_x, wx_q, wx_d;
  logic [YW-1:0]              y_q, y_d, eff_y, wy_q, wy_d;
  logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
  logic                       wvld_q, wvld_d;
  logic                       fd_q, fd_d;
  logic                       serr_q, serr_d;
  logic                       last_col, last_row;

  always_comb begin
    // sof re-anchors the pixel it qualifies to the frame origin.
    eff_x    = sof ? '0 : x_q;
    eff_y    = sof ? '0 : y_q;
    last_col = (eff_x == X_LAST);
    last_row = (eff_y == Y_LAST);

    x_d    = x_q;
    y_d    = y_q;
    win_d  = win_q;
    wvld_d = 1'b0;
    fd_d   = 1'b0;
    wx_d   = wx_q;
    wy_d   = wy_q;
    serr_d = serr_q;

    if (pixel_valid) begin
      if (sof && ((x_q != '0) || (y_q != '0))) begin
        serr_d = 1'b1;
      end

      x_d  = last_col ? '0 : eff_x + XW'(1);
      y_d  = last_col ? (last_row ? '0 : eff_y + YW'(1)) : eff_y;
      fd_d = last_col && last_row;

      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      // Line buffers are read before this cycle's write lands.
      win_d[0][2] = lb2[eff_x];
      win_d[1][2] = lb1[eff_x];
      win_d[2][2] = pixel_input;

      // Left-over columns from the previous row sit in the shift register
      // at row start; x >= 2 keeps them from ever being flagged.
      wvld_d = (eff_x >= XW'(2)) && (eff_y >= YW'(2));
      wx_d   = eff_x - XW'(1);
      wy_d   = eff_y - YW'(1);
    end
  end

  // Line buffer storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      lb2[eff_x] <= lb1[eff_x];
      lb1[eff_x] <= pixel_input;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q    <= '0;
      y_q    <= '0;
      win_q  <= '0;
      wvld_q <= 1'b0;
      fd_q   <= 1'b0;
      wx_q   <= '0;
      wy_q   <= '0;
      serr_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      win_q  <= win_d;
      wvld_q <= wvld_d;
      fd_q   <= fd_d;
      wx_q   <= wx_d;
      wy_q   <= wy_d;
      serr_q <= serr_d;
    end
  end

  assign pixel_window = win_q;
  assign window_valid = wvld_q;
  assign window_x     = wx_q;
  assign window_y     = wy_q;
  assign frame_done   = fd_q;
  assign sof_err      = serr_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: directed bench for sobel_window_gen (10x10 and 3x3 builds).
// Expected windows come from a ramp-image model pushed to a scoreboard queue
// when each cycle is driven and popped when the DUT output is sampled.
module tb_sobel_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [7:0]           pix;
  logic                 pv, sof_i;
  logic [2:0][2:0][7:0] pixel_window;
  logic                 window_valid, frame_done, sof_err;
  logic [3:0]           window_x, window_y;

  logic [7:0]           pix3;
  logic                 pv3, sof3;
  logic [2:0][2:0][7:0] pixel_window3;
  logic                 window_valid3, frame_done3, sof_err3;
  logic [1:0]           window_x3, window_y3;

  sobel_window_gen #(.IMG_WIDTH(10), .IMG_HEIGHT(10), .PIX_W(8)) dut (
    .clk(clk), .reset(reset), .pixel_input(pix), .pixel_valid(pv), .sof(sof_i),
    .pixel_window(pixel_window), .window_valid(window_valid),
    .window_x(window_x), .window_y(window_y),
    .frame_done(frame_done), .sof_err(sof_err)
  );

  sobel_window_gen #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .PIX_W(8)) dut3 (
    .clk(clk), .reset(reset), .pixel_input(pix3), .pixel_valid(pv3), .sof(sof3),
    .pixel_window(pixel_window3), .window_valid(window_valid3),
    .window_x(window_x3), .window_y(window_y3),
    .frame_done(frame_done3), .sof_err(sof_err3)
  );

  typedef struct packed {
    logic                 vld;
    logic                 fd;
    logic [3:0]           wx;
    logic [3:0]           wy;
    logic [2:0][2:0][7:0] win;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   win_cnt, fd_cnt, acc_cnt, first_acc;
  logic first_seen;
  logic [2:0][2:0][7:0] first_win, last_win;
  logic [3:0] first_x, first_y, last_x, last_y;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0][2:0][7:0] w9(input int a, b, c, d, e, f, g, h, i);
    logic [2:0][2:0][7:0] w;
    w[0][0] = 8'(a); w[0][1] = 8'(b); w[0][2] = 8'(c);
    w[1][0] = 8'(d); w[1][1] = 8'(e); w[1][2] = 8'(f);
    w[2][0] = 8'(g); w[2][1] = 8'(h); w[2][2] = 8'(i);
    return w;
  endfunction

  // Expected output for a ramp pixel (off + 10y + x) accepted at (x,y).
  function automatic exp_t mk(input int x, input int y, input int off);
    exp_t e;
    e     = '0;
    e.vld = (x >= 2) && (y >= 2);
    e.fd  = (x == 9) && (y == 9);
    e.wx  = 4'(x - 1);
    e.wy  = 4'(y - 1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        e.win[r][c] = 8'(off + 10 * (y - 2 + r) + (x - 2 + c));
    return e;
  endfunction

  task automatic cycle(input logic v, input logic s, input logic [7:0] p, input exp_t e);
    exp_t g;
    @(negedge clk);
    pv = v; sof_i = s; pix = p;
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    chk("window_valid", 72'(window_valid), 72'(g.vld));
    chk("frame_done", 72'(frame_done), 72'(g.fd));
    if (g.vld) begin
      chk("pixel_window", pixel_window, g.win);
      chk("window_x", 72'(window_x), 72'(g.wx));
      chk("window_y", 72'(window_y), 72'(g.wy));
    end
    if (window_valid === 1'b1) begin
      win_cnt++;
      if (!first_seen) begin
        first_seen = 1'b1;
        first_win  = pixel_window;
        first_x    = window_x;
        first_y    = window_y;
        first_acc  = acc_cnt;
      end
      last_win = pixel_window;
      last_x   = window_x;
      last_y   = window_y;
    end
    if (frame_done === 1'b1) fd_cnt++;
  endtask

  // Idle cycles carry random data and random sof, which must be ignored.
  task automatic idle();
    cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), '0);
  endtask

  task automatic send_px(input int x, input int y, input int off, input logic s);
    acc_cnt++;
    cycle(1'b1, s, 8'(off + 10 * y + x), mk(x, y, off));
  endtask

  task automatic send_frame(input int off, input logic s_first, input int gap_pct);
    for (int y = 0; y < 10; y++)
      for (int x = 0; x < 10; x++) begin
        while ($urandom_range(0, 99) < gap_pct) idle();
        send_px(x, y, off, s_first && (x == 0) && (y == 0));
      end
  endtask

  task automatic clr_stats();
    win_cnt = 0; fd_cnt = 0; acc_cnt = 0; first_seen = 1'b0; first_acc = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " window_valid"}, 72'(window_valid), 72'(0));
    chk({tag, " frame_done"}, 72'(frame_done), 72'(0));
    chk({tag, " sof_err"}, 72'(sof_err), 72'(0));
    chk({tag, " window_x"}, 72'(window_x), 72'(0));
    chk({tag, " window_y"}, 72'(window_y), 72'(0));
    chk({tag, " pixel_window"}, pixel_window, 72'(0));
  endtask

  initial begin
    reset = 1'b0; pv = 1'b0; sof_i = 1'b0; pix = '0;
    pv3 = 1'b0; sof3 = 1'b0; pix3 = '0;
    clr_stats();
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Continuous 10x10 ramp with sof on the first pixel.
    clr_stats();
    send_frame(0, 1'b1, 0);
    idle();
    chk("A win count", 72'(win_cnt), 72'(64));
    chk("A frame_done count", 72'(fd_cnt), 72'(1));
    chk("A first win", first_win, w9(0, 1, 2, 10, 11, 12, 20, 21, 22));
    chk("A first x", 72'(first_x), 72'(1));
    chk("A first y", 72'(first_y), 72'(1));
    chk("A last win", last_win, w9(77, 78, 79, 87, 88, 89, 97, 98, 99));
    chk("A last x", 72'(last_x), 72'(8));
    chk("A last y", 72'(last_y), 72'(8));
    chk("A sof_err", 72'(sof_err), 72'(0));

    // Same frame with ~50% random gaps.
    clr_stats();
    send_frame(0, 1'b1, 50);
    idle();
    chk("B win count", 72'(win_cnt), 72'(64));
    chk("B frame_done count", 72'(fd_cnt), 72'(1));
    chk("B last win", last_win, w9(77, 78, 79, 87, 88, 89, 97, 98, 99));
    chk("B sof_err", 72'(sof_err), 72'(0));

    // Back-to-back frames, no sof on the second.
    clr_stats();
    send_frame(0, 1'b1, 0);
    first_seen = 1'b0;
    send_frame(100, 1'b0, 0);
    idle();
    chk("C win count", 72'(win_cnt), 72'(128));
    chk("C frame_done count", 72'(fd_cnt), 72'(2));
    chk("C second first win", first_win, w9(100, 101, 102, 110, 111, 112, 120, 121, 122));
    chk("C second first x", 72'(first_x), 72'(1));
    chk("C second first y", 72'(first_y), 72'(1));
    chk("C sof_err", 72'(sof_err), 72'(0));

    // Partial frame up to (4,4), then sof at what would be (5,4).
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 10; x++) send_px(x, y, 0, 1'b0);
    for (int x = 0; x < 5; x++) send_px(x, 4, 0, 1'b0);
    chk("D sof_err before", 72'(sof_err), 72'(0));
    clr_stats();
    send_frame(0, 1'b1, 0);
    chk("D sof_err", 72'(sof_err), 72'(1));
    chk("D first window after sof pixel", 72'(first_acc), 72'(1 + 22));
    chk("D first x", 72'(first_x), 72'(1));
    chk("D first y", 72'(first_y), 72'(1));
    chk("D win count", 72'(win_cnt), 72'(64));

    // Asynchronous reset mid-frame after pixel (3,6).
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 10; x++) send_px(x, y, 0, 1'b0);
    for (int x = 0; x < 4; x++) send_px(x, 6, 0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("midframe reset");
    idle();
    idle();
    @(negedge clk) reset = 1'b1;
    clr_stats();
    send_frame(0, 1'b0, 0);
    idle();
    chk("E win count", 72'(win_cnt), 72'(64));
    chk("E first x", 72'(first_x), 72'(1));
    chk("E first y", 72'(first_y), 72'(1));
    chk("E first win", first_win, w9(0, 1, 2, 10, 11, 12, 20, 21, 22));
    chk("E frame_done count", 72'(fd_cnt), 72'(1));

    // 3x3 build, one 9-pixel frame of 1..9.
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      pv3 = 1'b1; pix3 = 8'(i); sof3 = (i == 1);
      @(posedge clk);
      #1;
      if (i < 9) begin
        chk("3x3 early valid", 72'(window_valid3), 72'(0));
        chk("3x3 early frame_done", 72'(frame_done3), 72'(0));
      end else begin
        chk("3x3 valid", 72'(window_valid3), 72'(1));
        chk("3x3 frame_done", 72'(frame_done3), 72'(1));
        chk("3x3 win", pixel_window3, w9(1, 2, 3, 4, 5, 6, 7, 8, 9));
        chk("3x3 x", 72'(window_x3), 72'(1));
        chk("3x3 y", 72'(window_y3), 72'(1));
      end
    end
    @(negedge clk);
    pv3 = 1'b0; sof3 = 1'b0;
    @(posedge clk);
    #1;
    chk("3x3 valid after", 72'(window_valid3), 72'(0));
    chk("3x3 frame_done after", 72'(frame_done3), 72'(0));
    chk("3x3 sof_err", 72'(sof_err3), 72'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
